rv_m_unit: RTL and testbench
============================

# rv_m_unit

Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the execute stage and is launched by a decoded M-type instruction. It produces a registered result with destination tag and write enable for the EX/MEM path. `busy` and `ready` drive the hazard unit stall.

## Interface
Parameters:
- XLEN, 32, operand/result width; must be a power of two ≥ 8.
- UNROLL, 1, iteration steps per cycle; must divide XLEN (1, 2, 4 supported).
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  launch strobe for one M-type instruction from EX.
- func3  in  3  RV32M funct3 select.
- op1  in  XLEN  rs1 value (already forwarded).
- op2  in  XLEN  rs2 value (already forwarded).
- rd  in  RA_W  destination register.
- flush  in  1  kill in-flight or just-launched operation (branch mispredict).
- busy  out  1  operation in progress.
- ready  out  1  one-cycle result-valid pulse.
- wr  out  1  register-file write request; equals ready && (dest != 0).
- dest  out  RA_W  destination tag of the completed operation.
- result  out  XLEN  completed result; holds until the next completion.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: start && !flush latches func3, operands, rd. Next state is CALC, or DONE directly for divide special cases.
- CALC: count N = XLEN/UNROLL iterations; when the final iteration retires, go to DONE.
- DONE: ready=1 for exactly one cycle, then IDLE. start && !flush in DONE is accepted back-to-back (DONE→CALC/DONE).
- start in CALC is ignored; the core guarantees no issue while busy.
- flush in CALC or DONE → IDLE; ready, wr and result remain unchanged/suppressed. flush with start in the same cycle: flush wins and start is dropped.
- Multiply: shift-add on operand magnitudes into a 2·XLEN accumulator, then conditional negate.
  - Sign rules: MULH treats both operands as signed; MULHSU treats op1 as signed, op2 as unsigned; MULHU and MUL treat both as unsigned magnitude.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Divide: restoring, one quotient bit per step, on magnitudes.
  - DIV: quotient is negated when operand signs differ.
  - REM: remainder takes the sign of the dividend.
  - DIVU/REMU: no sign handling.
- Special cases (resolved in IDLE, no CALC):
  - Divide by zero: quotient = all-ones; remainder = op1.
  - Signed overflow (DIV/REM of most-negative by −1): quotient = most-negative; remainder = 0.
- Reset (rst=0 at an edge, any state): IDLE; busy, ready, wr, result, dest = 0.

## Timing
- start sampled at edge k, normal path: busy=1 in cycles k+1…k+N; ready=1 (busy=0) in cycle k+N+1.
- Special-case path: ready=1 in cycle k+1; busy never asserts.
- Latency is independent of operand values for the normal path.
- ready, wr, dest and result are registered outputs; they change only on clk edges.
- Hazard unit stalls on busy || ready. The result is consumed in the ready cycle.

## Structure
- Package rv_m_pkg holds:
  - funct3 localparams (MUL=0 … REMU=7);
  - the state enum {IDLE, CALC, DONE};
  - an is_div(func3) helper;
  - an is_signed_op1 / is_signed_op2 decode function.
- Sub-module rv_m_step: combinational single-iteration step (add-shift for multiply, compare-subtract-shift for divide), instantiated UNROLL times in a chain.
- The top level holds the FSM, iteration counter ($clog2(N)+1 bits), operand/accumulator registers and sign fixup.

## Test plan
(XLEN=32, UNROLL=1; start at edge k.)
- MUL 7 × 0xFFFFFFFD, rd=5 → busy cycles k+1..k+32, ready/wr=1 at k+33, result 0xFFFFFFEB, dest 5.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7%2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both with ready at k+1. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same operands → 0.
- flush at k+10 → busy=0 at k+11, no ready through k+40. rd=0 op → ready=1, wr=0. start while busy → ignored, original result returned.
- rst=0 mid-CALC → all outputs 0 next cycle. New start in the DONE cycle → second ready exactly 33 cycles later.

Source files
------------

// File: rtl/rv_m_pkg.sv
// Shared decode for the RV32M multiply/divide unit: funct3 codes, FSM states, sign helpers.
// Pure definitions; no logic, no latency, no flow control.
package rv_m_pkg;

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] f);
    return (f == F_REM) || (f == F_REMU);
  endfunction

  function automatic logic is_signed_op1(input logic [2:0] f);
    return (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
  endfunction

  function automatic logic is_signed_op2(input logic [2:0] f);
    return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
  endfunction

endpackage

// File: rtl/rv_m_step.sv
// One combinational iteration: LSB-first shift-add for multiply, restoring compare-subtract for divide.
// Zero latency; no flow control (chained UNROLL times by the top).
module rv_m_step #(
  parameter int XLEN = 32
) (
  input  logic            div,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shl;
  logic [XLEN:0] diff;

  always_comb begin
    sum  = {1'b0, hi} + {1'b0, b};
    shl  = {hi, lo[XLEN-1]};
    diff = shl - {1'b0, b};
    if (div) begin
      // Remainder stays below the divisor, so diff[XLEN] is a clean borrow flag.
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shl[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else if (lo[0]) begin
      {hi_nxt, lo_nxt} = {sum, lo[XLEN-1:1]};
    end else begin
      {hi_nxt, lo_nxt} = {1'b0, hi, lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/rv_m_unit.sv
// Iterative RV32M unit: XLEN/UNROLL cycles in CALC then a one-cycle ready pulse; div special cases finish in one cycle.
// No backpressure: issue is held off by the hazard unit on busy || ready; flush kills the operation.
module rv_m_unit
  import rv_m_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int RA_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [RA_W-1:0] rd,
  input  logic            flush,
  output logic            busy,
  output logic            ready,
  output logic            wr,
  output logic [RA_W-1:0] dest,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_n;
  logic            launch;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic [RA_W-1:0] rd_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic            neg_q, neg_r_q;
  logic            ready_q, wr_q;
  logic [RA_W-1:0] dest_q;
  logic [XLEN-1:0] result_q;

  logic            s1, s2, div0, ovf, special;
  logic [XLEN-1:0] m1, m2, spec_res;

  always_comb begin
    s1      = is_signed_op1(func3) && op1[XLEN-1];
    s2      = is_signed_op2(func3) && op2[XLEN-1];
    m1      = s1 ? -op1 : op1;
    m2      = s2 ? -op2 : op2;
    div0    = is_div(func3) && (op2 == '0);
    ovf     = is_div(func3) && is_signed_op1(func3) && (op1 == MIN_NEG) && (op2 == '1);
    special = div0 || ovf;
    if (div0) spec_res = is_rem(func3) ? op1 : '1;
    else      spec_res = is_rem(func3) ? '0 : MIN_NEG;
  end

  logic                        op_div;
  logic [UNROLL:0][XLEN-1:0]   hi_c, lo_c;

  assign op_div  = is_div(f3_q);
  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    rv_m_step #(.XLEN(XLEN)) u_step (
      .div    (op_div),
      .b      (b_q),
      .hi     (hi_c[i]),
      .lo     (lo_c[i]),
      .hi_nxt (hi_c[i+1]),
      .lo_nxt (lo_c[i+1])
    );
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, calc_res;

  // Sign fixup applied to the final step output so the result lands with the ready pulse.
  always_comb begin
    prod = {hi_c[UNROLL], lo_c[UNROLL]};
    if (neg_q) prod = -prod;
    quo = neg_q   ? -lo_c[UNROLL] : lo_c[UNROLL];
    rem = neg_r_q ? -hi_c[UNROLL] : hi_c[UNROLL];
    case (f3_q)
      F_MUL:                     calc_res = prod[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: calc_res = prod[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             calc_res = quo;
      default:                   calc_res = rem;
    endcase
  end

  always_comb begin
    state_n = state;
    launch  = 1'b0;
    case (state)
      CALC: begin
        if (flush)                 state_n = IDLE;
        else if (cnt == CW'(1))    state_n = DONE;
      end
      default: begin
        state_n = IDLE;
        if (start && !flush) begin
          launch  = 1'b1;
          state_n = special ? DONE : CALC;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      ready_q  <= 1'b0;
      wr_q     <= 1'b0;
      dest_q   <= '0;
      result_q <= '0;
    end else begin
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      if (launch) begin
        f3_q    <= func3;
        rd_q    <= rd;
        cnt     <= CW'(N);
        hi_q    <= '0;
        lo_q    <= is_div(func3) ? m1 : m2;
        b_q     <= is_div(func3) ? m2 : m1;
        neg_q   <= s1 ^ s2;
        neg_r_q <= s1;
        if (special) begin
          ready_q  <= 1'b1;
          wr_q     <= (rd != '0);
          dest_q   <= rd;
          result_q <= spec_res;
        end
      end else if (state == CALC && !flush) begin
        hi_q <= hi_c[UNROLL];
        lo_q <= lo_c[UNROLL];
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          ready_q  <= 1'b1;
          wr_q     <= (rd_q != '0);
          dest_q   <= rd_q;
          result_q <= calc_res;
        end
      end
    end
  end

  assign busy   = (state == CALC);
  assign ready  = ready_q;
  assign wr     = wr_q;
  assign dest   = dest_q;
  assign result = result_q;

endmodule

// File: tb/tb_rv_m_unit.sv
// Directed plus randomized bench for rv_m_unit (XLEN=32, UNROLL=1) against an arithmetic reference model.
module tb_rv_m_unit;
  import rv_m_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [4:0]  rd = '0;
  logic        busy, ready, wr;
  logic [4:0]  dest;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_exp = '0;

  rv_m_unit #(.XLEN(32), .UNROLL(1), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3), .op1(op1), .op2(op2),
    .rd(rd), .flush(flush), .busy(busy), .ready(ready), .wr(wr), .dest(dest),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ps;
    logic [63:0] pu;
    pu = {32'b0, a} * {32'b0, b};
    case (f)
      F_MUL:    return pu[31:0];
      F_MULH:   begin ps = sa * sb; return ps[63:32]; end
      F_MULHSU: begin ps = sa * longint'({32'b0, b}); return ps[63:32]; end
      F_MULHU:  return pu[63:32];
      F_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      F_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      F_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == F_DIV || f == F_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Drives a start strobe for the cycle ending at the next rising edge; returns in the following cycle.
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    func3 = f; op1 = a; op2 = b; rd = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] r, input int lat0, input bit check_drop);
    int lat = lat0;
    bit busy_ok = 1'b1;
    logic [31:0] exp = ref_model(f, a, b);
    while (!ready && lat < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, lat, ref_latency(f, a, b));
    check({tag, "/busy_during"}, busy_ok, 1);
    check({tag, "/busy_at_ready"}, busy, 0);
    check({tag, "/result"}, result, exp);
    check({tag, "/dest"}, dest, r);
    check({tag, "/wr"}, wr, (r != 0));
    last_exp = exp;
    if (check_drop) begin
      @(negedge clk);
      check({tag, "/ready_pulse"}, ready, 0);
    end
  endtask

  logic [2:0]  df [13] = '{F_MUL, F_MULH, F_MULHU, F_MULHSU, F_DIV, F_REM, F_DIVU, F_REMU,
                           F_DIV, F_REM, F_DIV, F_REM, F_MUL};
  logic [31:0] da [13] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                           32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000,
                           32'h8000_0000, 32'd3};
  logic [31:0] db [13] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                           32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4};
  logic [4:0]  dr [13] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                           5'd11, 5'd12, 5'd0};

  initial begin
    bit seen_ready;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    logic [4:0]  rr;

    repeat (3) @(negedge clk);
    check("reset/busy", busy, 0);
    check("reset/ready", ready, 0);
    check("reset/wr", wr, 0);
    check("reset/dest", dest, 0);
    check("reset/result", result, 0);
    rst = 1'b1;
    @(negedge clk);

    // Spot-check the reference model on the documented constants.
    check("model/mul", ref_model(F_MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("model/mulhsu", ref_model(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

    for (int i = 0; i < 13; i++) begin
      launch(df[i], da[i], db[i], dr[i]);
      wait_done($sformatf("dir%0d", i), df[i], da[i], db[i], dr[i], 1, 1'b1);
    end

    // Back-to-back: second start sampled at the end of the DONE cycle.
    launch(F_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13);
    wait_done("b2b_first", F_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 1, 1'b0);
    launch(F_DIVU, 32'hDEAD_BEEF, 32'd1000, 5'd14);
    wait_done("b2b_second", F_DIVU, 32'hDEAD_BEEF, 32'd1000, 5'd14, 1, 1'b1);

    // Start while busy must be ignored.
    launch(F_REM, 32'hFFFF_FF00, 32'd7, 5'd15);
    repeat (3) @(negedge clk);
    func3 = F_MUL; op1 = 32'd2; op2 = 32'd3; rd = 5'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_busy", F_REM, 32'hFFFF_FF00, 32'd7, 5'd15, 5, 1'b1);

    // Flush mid-calculation: start at edge k, flush sampled at edge k+10.
    launch(F_MUL, 32'd11, 32'd13, 5'd16);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush/busy", busy, 0);
    seen_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (ready) seen_ready = 1'b1;
      @(negedge clk);
    end
    check("flush/no_ready", seen_ready, 0);
    check("flush/result_held", result, last_exp);

    // Flush together with start: start is dropped.
    func3 = F_DIV; op1 = 32'd5; op2 = 32'd0; rd = 5'd17; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start/busy", busy, 0);
    check("flush_start/ready", ready, 0);
    @(negedge clk);
    check("flush_start/ready2", ready, 0);

    // Synchronous reset mid-calculation.
    launch(F_MULH, 32'h8765_4321, 32'h1357_9BDF, 5'd18);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_calc/busy", busy, 0);
    check("rst_calc/ready", ready, 0);
    check("rst_calc/wr", wr, 0);
    check("rst_calc/dest", dest, 0);
    check("rst_calc/result", result, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      rr = 5'($urandom_range(0, 31));
      launch(rf, ra, rb, rr);
      wait_done($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, rr, 1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
